// File: rtl/multi_pkg.sv
// +--------------------------------------------------------------------------+
// | multi_pkg                                                                |
// | Shared encodings for the multi-cycle MIPS-subset control unit.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package multi_pkg;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_EXEC_R   = 4'd2;
  localparam state_t S_EXEC_I   = 4'd3;
  localparam state_t S_WB_ALU   = 4'd4;
  localparam state_t S_MEM_ADDR = 4'd5;
  localparam state_t S_MEM_RD   = 4'd6;
  localparam state_t S_MEM_WR   = 4'd7;
  localparam state_t S_WB_MEM   = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JUMP     = 4'd10;
  localparam state_t S_JR       = 4'd11;

  localparam logic [11:0] ALU_ADD   = 12'h001;
  localparam logic [11:0] ALU_SUB   = 12'h002;
  localparam logic [11:0] ALU_SLTU  = 12'h004;
  localparam logic [11:0] ALU_SLT   = 12'h008;
  localparam logic [11:0] ALU_AND   = 12'h010;
  localparam logic [11:0] ALU_OR    = 12'h020;
  localparam logic [11:0] ALU_NOR   = 12'h040;
  localparam logic [11:0] ALU_XOR   = 12'h080;
  localparam logic [11:0] ALU_SLL   = 12'h100;
  localparam logic [11:0] ALU_SRL   = 12'h200;
  localparam logic [11:0] ALU_SRA   = 12'h400;
  localparam logic [11:0] ALU_PASSB = 12'h800;

  typedef enum logic [1:0] {
    SRCA_PC = 2'd0,
    SRCA_RS = 2'd1,
    SRCA_RT = 2'd2
  } srca_e;

  typedef enum logic [2:0] {
    SRCB_RT       = 3'd0,
    SRCB_FOUR     = 3'd1,
    SRCB_SEXT     = 3'd2,
    SRCB_ZEXT     = 3'd3,
    SRCB_SEXT_SH2 = 3'd4,
    SRCB_LUI      = 3'd5,
    SRCB_SHAMT    = 3'd6,
    SRCB_RS       = 3'd7
  } srcb_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pcsrc_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

endpackage

`default_nettype wire

// File: rtl/multi_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | multi_ctrl_if                                                            |
// | Control-unit <-> datapath/memory signal bundle.                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface multi_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic        reg_dst;
  logic        mem_to_reg;
  logic [1:0]  alu_src_a;
  logic [2:0]  alu_src_b;
  logic [11:0] alu_f;
  logic        illegal;
  logic        bus_err;

  modport master (
    input  instr, alu_zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_f, illegal, bus_err
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_f, illegal, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/multi_alu_dec.sv
// +--------------------------------------------------------------------------+
// | multi_alu_dec                                                            |
// | {opcode, funct} -> ALU function and operand selects for EXEC states.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_alu_dec
  import multi_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  output logic [11:0] alu_f_o,
  output srca_e       src_a_o,
  output srcb_e       src_b_o,
  output logic        valid_o
);

  always_comb begin
    alu_f_o = ALU_ADD;
    src_a_o = SRCA_RS;
    src_b_o = SRCB_RT;
    valid_o = 1'b1;
    if (opcode_i == OP_RTYPE) begin
      // Shifts move A <- rt so the ALU computes rt shifted by B[4:0]
      case (funct_i)
        F_ADD, F_ADDU: alu_f_o = ALU_ADD;
        F_SUB, F_SUBU: alu_f_o = ALU_SUB;
        F_AND:  alu_f_o = ALU_AND;
        F_OR:   alu_f_o = ALU_OR;
        F_XOR:  alu_f_o = ALU_XOR;
        F_NOR:  alu_f_o = ALU_NOR;
        F_SLT:  alu_f_o = ALU_SLT;
        F_SLTU: alu_f_o = ALU_SLTU;
        F_SLL:  begin alu_f_o = ALU_SLL; src_a_o = SRCA_RT; src_b_o = SRCB_SHAMT; end
        F_SRL:  begin alu_f_o = ALU_SRL; src_a_o = SRCA_RT; src_b_o = SRCB_SHAMT; end
        F_SRA:  begin alu_f_o = ALU_SRA; src_a_o = SRCA_RT; src_b_o = SRCB_SHAMT; end
        F_SLLV: begin alu_f_o = ALU_SLL; src_a_o = SRCA_RT; src_b_o = SRCB_RS; end
        F_SRLV: begin alu_f_o = ALU_SRL; src_a_o = SRCA_RT; src_b_o = SRCB_RS; end
        F_SRAV: begin alu_f_o = ALU_SRA; src_a_o = SRCA_RT; src_b_o = SRCB_RS; end
        default: valid_o = 1'b0;
      endcase
    end else begin
      src_b_o = SRCB_SEXT;
      case (opcode_i)
        OP_ADDI, OP_ADDIU: alu_f_o = ALU_ADD;
        OP_SLTI:  alu_f_o = ALU_SLT;
        OP_SLTIU: alu_f_o = ALU_SLTU;
        OP_ANDI:  begin alu_f_o = ALU_AND;   src_b_o = SRCB_ZEXT; end
        OP_ORI:   begin alu_f_o = ALU_OR;    src_b_o = SRCB_ZEXT; end
        OP_XORI:  begin alu_f_o = ALU_XOR;   src_b_o = SRCB_ZEXT; end
        OP_LUI:   begin alu_f_o = ALU_PASSB; src_b_o = SRCB_LUI;  end
        default:  valid_o = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_ctrl.sv
// +--------------------------------------------------------------------------+
// | multi_ctrl                                                               |
// | Multi-cycle MIPS-subset control FSM with req/ready memory handshake.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_ctrl
  import multi_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  multi_ctrl_if.master bus
);

  localparam int unsigned c_CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic [c_CW-1:0] wait_q, wait_d;

  logic [5:0]  w_opcode, w_funct;
  logic        w_in_mem, w_timeout, w_ready;
  logic [11:0] w_dec_f;
  srca_e       w_dec_a;
  srcb_e       w_dec_b;
  logic        w_dec_valid;
  logic        w_unused;

  logic        w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we;
  logic [1:0]  w_pc_src, w_src_a;
  logic        w_reg_we, w_reg_dst, w_mem_to_reg;
  logic [2:0]  w_src_b;
  logic [11:0] w_alu_f;
  logic        w_illegal, w_bus_err;

  assign w_opcode = bus.instr[31:26];
  assign w_funct  = bus.instr[5:0];
  assign w_unused = ^bus.instr[25:6];

  assign w_in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // On expiry mem_req is already low, so a late mem_ready is simply ignored
  assign w_timeout = (MEM_TIMEOUT != 0) && w_in_mem && (wait_q == c_TIMEOUT);
  assign w_ready   = bus.mem_ready && !w_timeout;

  multi_alu_dec u_alu_dec (
    .opcode_i (w_opcode),
    .funct_i  (w_funct),
    .alu_f_o  (w_dec_f),
    .src_a_o  (w_dec_a),
    .src_b_o  (w_dec_b),
    .valid_o  (w_dec_valid)
  );

  always_comb begin
    state_d      = state_q;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = PC_ALU;
    w_reg_we     = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RT;
    w_alu_f      = ALU_ADD;
    w_illegal    = 1'b0;
    w_bus_err    = 1'b0;

    case (state_q)
      S_FETCH: begin
        w_src_b   = SRCB_FOUR;
        w_mem_req = !w_timeout;
        w_ir_we   = w_ready;
        w_pc_we   = w_ready;
        if (w_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        w_src_b = SRCB_SEXT_SH2;
        case (w_opcode)
          OP_RTYPE: state_d = (w_funct == F_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_EXEC_I;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        w_alu_f = w_dec_f;
        w_src_a = w_dec_a;
        w_src_b = w_dec_b;
        if (w_dec_valid) begin
          state_d = S_WB_ALU;
        end else begin
          w_illegal = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_WB_ALU: begin
        w_reg_we  = 1'b1;
        w_reg_dst = (w_opcode == OP_RTYPE);
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        w_src_a = SRCA_RS;
        w_src_b = SRCB_SEXT;
        state_d = (w_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        w_mem_req = !w_timeout;
        w_iord    = !w_timeout;
        w_mem_we  = !w_timeout && (state_q == S_MEM_WR);
        if (w_ready) state_d = (state_q == S_MEM_WR) ? S_FETCH : S_WB_MEM;
      end
      S_WB_MEM: begin
        w_reg_we     = 1'b1;
        w_mem_to_reg = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a  = SRCA_RS;
        w_src_b  = SRCB_RT;
        w_alu_f  = ALU_SUB;
        w_pc_src = PC_ALUOUT;
        w_pc_we  = bus.alu_zero ^ (w_opcode == OP_BNE);
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src = PC_JUMP;
        w_pc_we  = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        w_pc_src = PC_RS;
        w_pc_we  = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (w_timeout) begin
      w_bus_err = 1'b1;
      state_d   = S_FETCH;
    end

    if (rst) begin
      state_d      = S_FETCH;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_iord       = 1'b0;
      w_ir_we      = 1'b0;
      w_pc_we      = 1'b0;
      w_pc_src     = PC_ALU;
      w_reg_we     = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_src_a      = SRCA_PC;
      w_src_b      = SRCB_RT;
      w_alu_f      = ALU_ADD;
      w_illegal    = 1'b0;
      w_bus_err    = 1'b0;
    end
  end

  // Counter restarts whenever a memory state is entered or left
  assign wait_d = (w_in_mem && (state_d == state_q) && !w_timeout) ? wait_q + c_CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.iord       = w_iord;
  assign bus.ir_we      = w_ir_we;
  assign bus.pc_we      = w_pc_we;
  assign bus.pc_src     = w_pc_src;
  assign bus.reg_we     = w_reg_we;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.alu_f      = w_alu_f;
  assign bus.illegal    = w_illegal;
  assign bus.bus_err    = w_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_multi_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_multi_ctrl                                                            |
// | Cycle-by-cycle scoreboard bench for the multi-cycle control unit.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multi_ctrl;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic        reg_dst;
    logic        mem_to_reg;
    logic [1:0]  src_a;
    logic [2:0]  src_b;
    logic [11:0] alu_f;
    logic        illegal;
    logic        bus_err;
  } outs_t;

  typedef struct packed {
    logic rst_v;
    logic rdy;
    logic zero;
  } stim_t;

  typedef struct packed {
    outs_t exp;
    outs_t care;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_ctrl_if bus ();

  multi_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  stim_t  stim_q[$];
  entry_t exp_q[$];
  int     checks = 0;
  int     passes = 0;

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.alu_f = 12'h001;
    return o;
  endfunction

  // alu: compare ALU selects/function; pcs: compare pc_src
  function automatic outs_t care(input logic alu, input logic pcs);
    outs_t c;
    c = '1;
    if (!alu) begin c.src_a = '0; c.src_b = '0; c.alu_f = '0; end
    if (!pcs) c.pc_src = '0;
    return c;
  endfunction

  function automatic outs_t e_fetch(input logic r);
    outs_t o;
    o = base(); o.mem_req = 1'b1; o.src_b = 3'd1; o.ir_we = r; o.pc_we = r;
    return o;
  endfunction

  function automatic outs_t e_decode(input logic ill);
    outs_t o;
    o = base(); o.src_b = 3'd4; o.illegal = ill;
    return o;
  endfunction

  function automatic outs_t e_exec(input logic [11:0] f, input logic [1:0] a, input logic [2:0] b);
    outs_t o;
    o = base(); o.alu_f = f; o.src_a = a; o.src_b = b;
    return o;
  endfunction

  function automatic outs_t e_mem(input logic we);
    outs_t o;
    o = base(); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = we;
    return o;
  endfunction

  function automatic outs_t e_branch(input logic pw);
    outs_t o;
    o = e_exec(12'h002, 2'd1, 3'd0); o.pc_src = 2'd1; o.pc_we = pw;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.mem_req = bus.mem_req;     o.mem_we = bus.mem_we;   o.iord = bus.iord;
    o.ir_we = bus.ir_we;         o.pc_we = bus.pc_we;     o.pc_src = bus.pc_src;
    o.reg_we = bus.reg_we;       o.reg_dst = bus.reg_dst; o.mem_to_reg = bus.mem_to_reg;
    o.src_a = bus.alu_src_a;     o.src_b = bus.alu_src_b; o.alu_f = bus.alu_f;
    o.illegal = bus.illegal;     o.bus_err = bus.bus_err;
    return o;
  endfunction

  task automatic push(input logic r, input logic rdy, input logic z, input outs_t e, input outs_t c);
    stim_q.push_back('{rst_v: r, rdy: rdy, zero: z});
    exp_q.push_back('{exp: e, care: c});
  endtask

  task automatic drain(input string name);
    stim_t  s;
    entry_t e;
    outs_t  obs;
    int     step;
    step = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst = s.rst_v;
      bus.mem_ready = s.rdy;
      bus.alu_zero = s.zero;
      @(negedge clk);
      obs = sample();
      checks++;
      if ((obs & e.care) !== (e.exp & e.care))
        $display("FAIL %s step %0d: got %h, expected %h (care %h)", name, step, obs, e.exp, e.care);
      else
        passes++;
      step++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.instr = 32'h00221820;
    push(1, 1, 0, base(), care(1, 1));
    push(1, 1, 0, base(), care(1, 1));
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, e_exec(12'h001, 2'd1, 3'd0), care(1, 1));
    push(0, 1, 0, '{reg_we: 1'b1, reg_dst: 1'b1, alu_f: 12'h001, default: '0}, care(0, 0));
    drain("reset");
  endtask

  task automatic test_add_fetch_wait();
    bus.instr = 32'h00221820;
    push(0, 0, 0, e_fetch(0), care(1, 1));
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, e_exec(12'h001, 2'd1, 3'd0), care(1, 1));
    push(0, 1, 0, '{reg_we: 1'b1, reg_dst: 1'b1, alu_f: 12'h001, default: '0}, care(0, 0));
    drain("add_wait");
  endtask

  task automatic test_rtype();
    logic [5:0]  fn[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [11:0] ef[16] = '{12'h001, 12'h001, 12'h002, 12'h002, 12'h010, 12'h020, 12'h080, 12'h040,
                            12'h008, 12'h004, 12'h100, 12'h200, 12'h400, 12'h100, 12'h200, 12'h400};
    logic [1:0]  ea[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2};
    logic [2:0]  eb[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 6, 6, 7, 7, 7};
    for (int i = 0; i < 16; i++) begin
      bus.instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd4, fn[i]};
      push(0, 1, 0, e_fetch(1), care(1, 1));
      push(0, 1, 0, e_decode(0), care(1, 1));
      push(0, 0, 0, e_exec(ef[i], ea[i], eb[i]), care(1, 1));
      push(0, 1, 0, '{reg_we: 1'b1, reg_dst: 1'b1, alu_f: 12'h001, default: '0}, care(0, 0));
      drain($sformatf("rtype_f%02h", fn[i]));
    end
  endtask

  task automatic test_itype();
    logic [5:0]  op[8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [11:0] ef[8] = '{12'h001, 12'h001, 12'h008, 12'h004, 12'h010, 12'h020, 12'h080, 12'h800};
    logic [2:0]  eb[8] = '{2, 2, 2, 2, 3, 3, 3, 5};
    outs_t c;
    for (int i = 0; i < 8; i++) begin
      bus.instr = {op[i], 5'd1, 5'd2, 16'h8123};
      c = care(1, 1);
      if (op[i] == 6'h0F) c.src_a = '0;
      push(0, 1, 0, e_fetch(1), care(1, 1));
      push(0, 1, 0, e_decode(0), care(1, 1));
      push(0, 1, 0, e_exec(ef[i], 2'd1, eb[i]), c);
      push(0, 1, 0, '{reg_we: 1'b1, alu_f: 12'h001, default: '0}, care(0, 0));
      drain($sformatf("itype_op%02h", op[i]));
    end
  endtask

  task automatic test_lw_wait();
    bus.instr = 32'h8C240008;
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, e_exec(12'h001, 2'd1, 3'd2), care(1, 1));
    push(0, 0, 0, e_mem(0), care(0, 0));
    push(0, 0, 0, e_mem(0), care(0, 0));
    push(0, 1, 0, e_mem(0), care(0, 0));
    push(0, 1, 0, '{reg_we: 1'b1, mem_to_reg: 1'b1, alu_f: 12'h001, default: '0}, care(0, 0));
    drain("lw_wait");
  endtask

  task automatic test_sw();
    bus.instr = 32'hAC240010;
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 0, 0, e_exec(12'h001, 2'd1, 3'd2), care(1, 1));
    push(0, 1, 0, e_mem(1), care(0, 0));
    drain("sw");
  endtask

  task automatic test_branch();
    logic [5:0] op[4] = '{6'h04, 6'h05, 6'h04, 6'h05};
    logic       z[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       pw[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.instr = {op[i], 5'd1, 5'd2, 16'hFFFE};
      push(0, 1, ~z[i], e_fetch(1), care(1, 1));
      push(0, 1, ~z[i], e_decode(0), care(1, 1));
      push(0, 1, z[i], e_branch(pw[i]), care(1, 1));
      drain($sformatf("branch_op%02h_z%0d", op[i], z[i]));
    end
  endtask

  task automatic test_jump();
    bus.instr = 32'h08000040;
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, '{pc_we: 1'b1, pc_src: 2'd2, alu_f: 12'h001, default: '0}, care(0, 1));
    drain("j");
    bus.instr = 32'h03E00008;
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, '{pc_we: 1'b1, pc_src: 2'd3, alu_f: 12'h001, default: '0}, care(0, 1));
    drain("jr");
  endtask

  task automatic test_illegal();
    bus.instr = 32'hFC000000;
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(1), care(1, 1));
    drain("illegal_op");
    bus.instr = 32'h0022183F;
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, '{illegal: 1'b1, default: '0}, care(0, 0));
    drain("illegal_funct");
  endtask

  task automatic test_timeout();
    bus.instr = 32'hAC240010;
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, e_exec(12'h001, 2'd1, 3'd2), care(1, 1));
    for (int i = 0; i < 4; i++) push(0, 0, 0, e_mem(1), care(0, 0));
    begin
      outs_t c;
      c = care(0, 0);
      c.iord = 1'b0;
      c.mem_we = 1'b0;
      push(0, 1, 0, '{bus_err: 1'b1, alu_f: 12'h001, default: '0}, c);
    end
    drain("timeout");
  endtask

  task automatic test_reset_mid_wait();
    bus.instr = 32'h8C240008;
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, e_exec(12'h001, 2'd1, 3'd2), care(1, 1));
    push(0, 0, 0, e_mem(0), care(0, 0));
    push(0, 0, 0, e_mem(0), care(0, 0));
    push(1, 1, 0, base(), care(1, 1));
    push(0, 1, 0, e_fetch(1), care(1, 1));
    push(0, 1, 0, e_decode(0), care(1, 1));
    push(0, 1, 0, e_exec(12'h001, 2'd1, 3'd2), care(1, 1));
    push(0, 1, 0, e_mem(0), care(0, 0));
    push(0, 1, 0, '{reg_we: 1'b1, mem_to_reg: 1'b1, alu_f: 12'h001, default: '0}, care(0, 0));
    push(0, 0, 0, e_fetch(0), care(1, 1));
    drain("reset_mid_wait");
  endtask

  initial begin
    rst = 1'b1;
    bus.instr = '0;
    bus.mem_ready = 1'b1;
    bus.alu_zero = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_add_fetch_wait();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_ctrl.md
Name: multi_ctrl

Overview:
- Multi-cycle control unit for the 32-bit MIPS-subset multi-cycle CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath muxes and write enables, and produces the ALU's 12-bit one-hot function select.
- Handshakes with instruction/data memory through a req/ready pair that tolerates wait states.

Parameters:
- MEM_TIMEOUT, 0, maximum cycles to wait for mem_ready per access; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents, valid from DECODE onward
- alu_zero  in  1  high when the ALU result equals 0
- mem_ready  in  1  memory access complete this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write, qualifies mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target {PC[31:28], instr[25:0], 2'b00}, 3 = rs
- reg_we  out  1  register file write
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- alu_src_a  out  2  ALU A input: 0 = PC, 1 = rs, 2 = rt
- alu_src_b  out  3  ALU B input: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = zero-extended imm, 4 = sign-extended imm<<2, 5 = imm<<16, 6 = zero-extended shamt, 7 = rs
- alu_f  out  12  one-hot ALU function select
- illegal  out  1  one-cycle pulse on an undecodable instruction
- bus_err  out  1  one-cycle pulse on a memory timeout

Behaviour:
- alu_f one-hot bit assignment: 0 ADD, 1 SUB, 2 SLTU, 3 SLT, 4 AND, 5 OR, 6 NOR, 7 XOR, 8 SLL, 9 SRL, 10 SRA, 11 PASSB. Exactly one bit is set in every state.
- Shifts compute A shifted by B[4:0]. Shift instructions therefore use alu_src_a = rt and alu_src_b = shamt (fixed shifts) or rs (variable shifts).
- State register is synchronous. Outputs are Moore, except the mem_ready-qualified strobes noted below.
- Reset: state = FETCH. While rst is high, all enables, mem_req, illegal and bus_err are 0, alu_f = ADD, and all selects are 0.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = PC, alu_src_b = 4, ADD.
  - ir_we = pc_we = mem_ready, with pc_src = 0.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_a = PC, alu_src_b = imm<<2, ADD; this latches the branch target into ALUOut. Next state is chosen by opcode:
  - R-type → EXEC_R; except funct jr (0x08) → JR.
  - addi/addiu/slti/sltiu/andi/ori/xori/lui → EXEC_I.
  - lw/sw → MEM_ADDR.
  - beq/bne → BRANCH.
  - j → JUMP.
  - Anything else → FETCH with an illegal pulse.
- EXEC_R: alu_f decoded from funct.
  - add/addu → ADD; sub/subu → SUB.
  - and/or/xor/nor, slt/sltu → matching ALU function.
  - sll/srl/sra → matching shift with B = shamt.
  - sllv/srlv/srav → matching shift with B = rs.
  - Unknown funct → FETCH with an illegal pulse.
  - Otherwise → WB_ALU.
- EXEC_I:
  - addi/addiu → ADD with sign-extended imm.
  - slti → SLT and sltiu → SLTU, both with sign-extended imm.
  - andi/ori/xori → matching logic op with zero-extended imm.
  - lui → PASSB with imm<<16.
  - Then → WB_ALU.
- WB_ALU: reg_we = 1, reg_dst = 1 for R-type and 0 for I-type, mem_to_reg = 0 → FETCH.
- MEM_ADDR: rs + sign-extended imm (ADD) → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req = 1, iord = 1, mem_we = 0. Stays until mem_ready, then → WB_MEM.
- MEM_WR: mem_req = 1, iord = 1, mem_we = 1. Stays until mem_ready, then → FETCH.
- WB_MEM: reg_we = 1, reg_dst = 0, mem_to_reg = 1 → FETCH.
- BRANCH: rs SUB rt, pc_src = 1, pc_we = alu_zero XOR is_bne → FETCH.
- JUMP: pc_src = 2, pc_we = 1 → FETCH.
- JR: pc_src = 3, pc_we = 1 → FETCH.
- Latency, in cycles with zero wait states: R/I-type 4, lw 5, sw 4, branch 3, j/jr 3. Each wait cycle adds 1.
- Handshake rules:
  - mem_req, mem_we and iord stay stable until the cycle in which mem_ready is sampled high.
  - mem_ready while mem_req is low is ignored.
  - mem_req drops in the cycle after acceptance unless the next state also requests.
- Timeout: a wait counter clears on entry to each memory state. If MEM_TIMEOUT > 0 and the counter reaches MEM_TIMEOUT without mem_ready, pulse bus_err, go to FETCH and drop mem_req; no register or PC write occurs.
- Reset asserted in any state, including mid-wait, takes priority: the next state is FETCH and no strobe fires in that cycle.

Decomposition:
- Shared package multi_pkg holds:
  - the state enum;
  - ALU one-hot localparams ALU_ADD..ALU_PASSB;
  - the alu_src_a, alu_src_b and pc_src enums;
  - opcode and funct constants.
- One natural sub-module, multi_alu_dec: combinational {opcode, funct} → {alu_f, alu_src_a, alu_src_b, valid}. It is used by EXEC_R and EXEC_I.

Test Plan:
- Reset release with mem_ready tied high: FETCH asserts mem_req=1, iord=0, alu_f=12'h001; ir_we and pc_we pulse in the first cycle; DECODE follows.
- add $3,$1,$2 (0x00221820) with zero wait states: 4 cycles; EXEC_R alu_f=12'h001, alu_src_b=0; WB_ALU reg_we=1, reg_dst=1.
- lw $4,8($1) (0x8C240008) with mem_ready delayed 2 cycles in MEM_RD: mem_req held stable for 3 cycles; WB_MEM reg_we=1, mem_to_reg=1; total 7 cycles.
- beq with alu_zero=1 → pc_we=1, pc_src=1; bne with alu_zero=1 → pc_we=0; each takes 3 cycles.
- Opcode 0x3F → illegal pulses exactly once in DECODE and the next state is FETCH. R-type funct 0x3F → illegal pulses in EXEC_R.
- MEM_TIMEOUT=4 with mem_ready held low in MEM_WR → bus_err pulses after 4 cycles, no pc_we or reg_we, back to FETCH. Separately, rst asserted mid MEM_RD → FETCH next cycle with all strobes 0.
